// File: rtl/fifo_burst_pkg.sv
// fifo_burst_pkg: shared FSM state type and burst sizing helper for fifo_burst_reader
package fifo_burst_pkg;
  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_e;
  function automatic int unsigned min_beats(input int unsigned usage, input int unsigned len);
    return (usage < len) ? usage : len;
  endfunction
endpackage

// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if: upstream FIFO pop port plus downstream valid/ready burst stream
//   fifo_empty/fifo_usage/fifo_data in, fifo_pop out; valid/data/burst_last out, ready in
//   master = reader side, slave = FIFO + consumer side
interface fifo_burst_reader_if
  import fifo_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 8,
  parameter type dtype = logic [DATA_WIDTH-1:0]
);
  localparam int ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic fifo_empty;
  logic [ADDR_DEPTH:0] fifo_usage;
  dtype fifo_data;
  logic fifo_pop;
  logic valid;
  logic ready;
  dtype data;
  logic burst_last;
  modport master(input fifo_empty, fifo_usage, fifo_data, ready, output fifo_pop, valid, data, burst_last);
  modport slave(output fifo_empty, fifo_usage, fifo_data, ready, input fifo_pop, valid, data, burst_last);
endinterface

// File: rtl/fifo_burst_obuf.sv
// fifo_burst_obuf: 2-entry registered stream buffer carrying {last, payload}
//   clk/rst/flush: clock, sync reset, one-cycle clear
//   push/push_data/push_last: write side (never pushed while full)
//   full: both entries occupied; valid/ready/data/last: stream head
module fifo_burst_obuf
  import fifo_burst_pkg::*;
#(
  parameter type dtype = logic [31:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  dtype push_data,
  input  logic push_last,
  output logic full,
  output logic valid,
  input  logic ready,
  output dtype data,
  output logic last
);
  logic [1:0] count;
  dtype d0, d1;
  logic l0, l1;
  logic hs;
  assign valid = count != 2'd0;
  assign full = count == 2'd2;
  assign hs = valid && ready;
  assign data = d0;
  assign last = l0;
  // Head refills from entry 1, or straight from the push when it is the only entry leaving.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
      d0 <= '0;
      d1 <= '0;
      l0 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      count <= count + 2'(push) - 2'(hs);
      if (hs) begin
        d0 <= (push && count == 2'd1) ? push_data : d1;
        l0 <= (push && count == 2'd1) ? push_last : l1;
      end else if (push && count == 2'd0) begin
        d0 <= push_data;
        l0 <= push_last;
      end
      if (push && (hs ? count == 2'd2 : count == 2'd1)) begin
        d1 <= push_data;
        l1 <= push_last;
      end
    end
  end
endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a non-fall-through FIFO into a valid/ready stream in counted bursts
//   clk_i/rst_i: clock, sync active-high reset; flush_i: abort burst, clear state
//   bus (master): FIFO empty/usage/data in, pop out; stream valid/data/burst_last out, ready in
//   busy_o: FSM not idle
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT = 16,
  parameter type dtype = logic [DATA_WIDTH-1:0]
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  output logic busy_o,
  fifo_burst_reader_if.master bus
);
  localparam int ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int UW = ADDR_DEPTH + 1;
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [UW-1:0] BL_U = UW'(BURST_LEN);
  localparam logic [TW-1:0] TO_T = TW'(TIMEOUT);
  if (DEPTH < 1) begin : g_bad_depth
    $error("fifo_burst_reader: DEPTH must be >= 1");
  end
  if (BURST_LEN < 1 || BURST_LEN > DEPTH) begin : g_bad_len
    $error("fifo_burst_reader: BURST_LEN must be in 1..DEPTH");
  end
  state_e state, state_n;
  logic [BW-1:0] beats, beats_n;
  logic [TW-1:0] timer, timer_n;
  logic clr, go, pop, full, valid, last, hs;
  dtype data;
  assign clr = rst_i || flush_i;
  assign hs = valid && bus.ready;
  always_comb begin
    go = bus.fifo_usage >= BL_U || (TIMEOUT != 0 && bus.fifo_usage != '0 && timer == TO_T);
    // full is registered, so ready never reaches pop combinationally
    pop = state == BURST && !bus.fifo_empty && beats != '0 && !full && !clr;
    state_n = (state == IDLE && go) ? BURST :
              (state == BURST && pop && beats == BW'(1)) ? DRAIN :
              (state == DRAIN && hs && last) ? IDLE : state;
    beats_n = (state == IDLE && go) ? BW'(min_beats(32'(bus.fifo_usage), BURST_LEN)) :
              pop ? beats - BW'(1) : beats;
    timer_n = (state != IDLE || go || bus.fifo_usage == '0) ? '0 :
              (timer == TO_T) ? timer : timer + TW'(1);
  end
  always_ff @(posedge clk_i) begin
    if (clr) begin
      state <= IDLE;
      beats <= '0;
      timer <= '0;
    end else begin
      state <= state_n;
      beats <= beats_n;
      timer <= timer_n;
    end
  end
  fifo_burst_obuf #(.dtype(dtype)) u_obuf (
    .clk(clk_i),
    .rst(rst_i),
    .flush(flush_i),
    .push(pop),
    .push_data(bus.fifo_data),
    .push_last(beats == BW'(1)),
    .full(full),
    .valid(valid),
    .ready(bus.ready),
    .data(data),
    .last(last)
  );
  assign bus.fifo_pop = pop;
  assign bus.valid = valid;
  assign bus.data = data;
  assign bus.burst_last = last;
  assign busy_o = state != IDLE;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed + randomized bench with a queue FIFO model and stream scoreboard
module tb_fifo_burst_reader;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int BL = 4;
  localparam int TO = 16;
  localparam int UW = $clog2(DEPTH) + 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic busy;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fifo_burst_reader_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();
  fifo_burst_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .flush_i(flush),
    .busy_o(busy),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Upstream FIFO model: src holds everything ever written, entering the FIFO as space allows.
  logic [DW-1:0] src[$];
  logic [DW-1:0] fq[$];
  int src_ptr = 0;
  always @(posedge clk) begin
    if (bus.fifo_pop && fq.size() > 0) void'(fq.pop_front());
    while (src_ptr < src.size() && fq.size() < DEPTH) begin
      fq.push_back(src[src_ptr]);
      src_ptr++;
    end
    bus.fifo_empty <= fq.size() == 0;
    bus.fifo_usage <= UW'(fq.size());
    bus.fifo_data <= fq.size() > 0 ? fq[0] : '0;
  end
  // Stream scoreboard: popped words must emerge in order; bq lists expected burst lengths.
  logic [DW-1:0] infl[$];
  int bq[$];
  int bq_ptr = 0;
  int beat = 0;
  int hs_cnt = 0;
  int pop_cnt = 0;
  int last_cnt = 0;
  logic pv = 1'b0, pr = 1'b0, prf = 1'b1, pp = 1'b0, exp_last;
  logic [DW-1:0] pd = '0;
  always @(negedge clk) begin
    if (rst || flush) begin
      chk("pop_in_clear", bus.fifo_pop, 0);
      infl.delete();
      beat = 0;
      bq_ptr = bq.size();
    end else begin
      if (pp) chk("pop_to_valid", bus.valid, 1);
      if (pv && !pr && !prf) begin
        chk("hold_valid", bus.valid, 1);
        chk("hold_data", bus.data, pd);
      end
      if (bus.valid && bus.ready) begin
        hs_cnt++;
        beat++;
        chk("beat_expected", infl.size() > 0 && bq_ptr < bq.size(), 1);
        if (infl.size() > 0) chk("order", bus.data, infl.pop_front());
        exp_last = bq_ptr < bq.size() && beat == bq[bq_ptr];
        chk("last", bus.burst_last, exp_last);
        if (bus.burst_last) last_cnt++;
        if (exp_last) begin
          bq_ptr++;
          beat = 0;
        end
      end
      if (bus.fifo_pop) begin
        infl.push_back(bus.fifo_data);
        pop_cnt++;
      end
      chk("buffered_le_2", infl.size() <= 2, 1);
    end
    pv = bus.valid;
    pr = bus.ready;
    prf = rst || flush;
    pd = bus.data;
    pp = bus.fifo_pop && !(rst || flush);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) src.push_back($urandom);
  endtask
  task automatic expect_bursts(input int n);
    for (int i = 0; i < n / BL; i++) bq.push_back(BL);
    if (n % BL != 0) bq.push_back(n % BL);
  endtask
  task automatic wait_done(input string tag, input int target, input int budget, input bit rnd);
    int i = 0;
    while ((hs_cnt < target || busy) && i < budget) begin
      if (rnd) bus.ready = 1'($urandom_range(0, 1));
      tick();
      i++;
    end
    bus.ready = 1'b1;
    chk(tag, {hs_cnt == target, busy}, 2'b10);
  endtask
  task automatic wait_hs(input string tag, input int target);
    int i = 0;
    while (hs_cnt < target && i < 40) begin
      tick();
      i++;
    end
    chk(tag, hs_cnt >= target, 1);
  endtask
  initial begin
    int base, idle, rem, n;
    bus.ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", bus.valid, 0);
    chk("rst_pop", bus.fifo_pop, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last", bus.burst_last, 0);
    chk("rst_data", bus.data, 0);
    rst = 1'b0;
    tick();
    // full burst, consumer always ready
    bus.ready = 1'b1;
    base = hs_cnt;
    n = last_cnt;
    bq.push_back(BL);
    push_n(4);
    idle = 0;
    while (!bus.fifo_pop && idle < 10) begin
      tick();
      idle++;
    end
    chk("t1_pop_start", bus.fifo_pop, 1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("t1_pop_consec", bus.fifo_pop, 1);
    end
    tick();
    chk("t1_pop_stop", bus.fifo_pop, 0);
    wait_done("t1_done", base + 4, 20, 0);
    chk("t1_one_last", last_cnt - n, 1);
    // partial fill waits for the timeout
    base = hs_cnt;
    bq.push_back(2);
    push_n(2);
    idle = 0;
    while (!bus.fifo_pop && idle < 60) begin
      tick();
      idle++;
    end
    chk("t2_timeout_wait", idle >= TO && idle <= TO + 3, 1);
    wait_done("t2_done", base + 2, 20, 0);
    // back-pressure mid-burst
    base = hs_cnt;
    bq.push_back(BL);
    push_n(4);
    wait_hs("t3_first_beat", base + 1);
    bus.ready = 1'b0;
    repeat (5) begin
      tick();
      chk("t3_valid_held", bus.valid, 1);
    end
    bus.ready = 1'b1;
    wait_done("t3_done", base + 4, 20, 0);
    // flush mid-burst; leftovers form a new burst
    base = hs_cnt;
    bq.push_back(BL);
    push_n(4);
    wait_hs("t4_first_beat", base + 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_valid_after_flush", bus.valid, 0);
    chk("t4_busy_after_flush", busy, 0);
    rem = fq.size();
    chk("t4_leftover", rem > 0 && rem < BL, 1);
    expect_bursts(rem);
    wait_done("t4_done", hs_cnt + rem, 60, 0);
    chk("t4_fifo_empty", fq.size(), 0);
    // reset while draining
    n = pop_cnt;
    bq.push_back(BL);
    push_n(4);
    idle = 0;
    while (pop_cnt < n + 4 && idle < 20) begin
      tick();
      idle++;
    end
    bus.ready = 1'b0;
    chk("t5_draining", {busy, bus.valid, bus.fifo_pop}, 3'b110);
    rst = 1'b1;
    tick();
    chk("t5_rst_outputs", {busy, bus.valid, bus.burst_last, bus.fifo_pop}, 4'b0000);
    chk("t5_rst_data", bus.data, 0);
    rst = 1'b0;
    bus.ready = 1'b1;
    tick();
    chk("t5_idle_after_rst", {busy, bus.valid}, 2'b00);
    // nine entries into an eight-deep FIFO with random back-pressure: 4, 4, then a timeout 1
    base = hs_cnt;
    bq.push_back(4);
    bq.push_back(4);
    bq.push_back(1);
    push_n(9);
    wait_done("t6_done", base + 9, 400, 1);
    // random fills, all arriving at once
    repeat (6) begin
      n = $urandom_range(1, DEPTH);
      base = hs_cnt;
      expect_bursts(n);
      push_n(n);
      wait_done("rand_done", base + n, 400, 1);
    end
    tick();
    chk("final_empty", {infl.size() == 0, fq.size() == 0, bq_ptr == bq.size()}, 3'b111);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
